// File: rtl/intersection_pkg.sv
// Shared types and constants for the two-way intersection sequencer.
// Imported by the interface, the phase counter and the controller top.
package intersection_pkg;

   typedef enum logic [1:0] {
      NS_GO = 2'd0,
      EW_GO = 2'd1,
      CLEAR = 2'd2
   } state_e;

   typedef enum logic {
      NS = 1'b0,
      EW = 1'b1
   } dir_e;

   localparam int TIMER_W   = 7;
   localparam int RED_W     = 4;
   localparam int YELLOW_TH = 15;
   localparam int TIMER_MAX = (1 << TIMER_W) - 1;
   localparam int RED_MAX   = (1 << RED_W) - 1;

   function automatic dir_e other_dir(input dir_e d);
      return (d == NS) ? EW : NS;
   endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Sensor/strobe inputs and light-drive outputs of the sequencer.
// master drives sensors and tick; slave is the controller.
interface intersection_controller_if;
   import intersection_pkg::*;

   logic               tick;
   logic               car_ns;
   logic               car_ew;
   logic               ns_enable;
   logic [TIMER_W-1:0] ns_timer;
   logic               ew_enable;
   logic [TIMER_W-1:0] ew_timer;
   logic               ns_wait;
   logic               ew_wait;

   modport master (
      output tick, car_ns, car_ew,
      input  ns_enable, ns_timer, ew_enable, ew_timer,
      input  ns_wait, ew_wait
   );

   modport slave (
      input  tick, car_ns, car_ew,
      output ns_enable, ns_timer, ew_enable, ew_timer,
      output ns_wait, ew_wait
   );

endinterface

// File: rtl/intersection_controller_phase_counter.sv
// Tick-gated loadable down-counter; stops at zero, flags 0 and 1.
// Used for both the phase timer and the all-red clearance count.
module phase_counter #(
   parameter int          W       = 7,
   parameter int unsigned RST_VAL = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count,
   output logic         zero,
   output logic         one
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= W'(RST_VAL);
      end else if (tick) begin
         if (load) begin
            count <= load_val;
         end else if (dec && count != '0) begin
            count <= count - W'(1);
         end
      end
   end

   assign zero = (count == '0);
   assign one  = (count == W'(1));

endmodule

// File: rtl/intersection_controller.sv
// Two-way intersection sequencer: GO/CLEAR FSM, grant logic and
// request latches driving the enable/timer inputs of two lights.
module intersection_controller
   import intersection_pkg::*;
#(
   parameter int LOAD    = 60,
   parameter int ALL_RED = 2
) (
   input logic                      clk,
   input logic                      reset,
   intersection_controller_if.slave bus
);

   if (LOAD <= YELLOW_TH || LOAD > TIMER_MAX) begin : g_bad_load
      $error("LOAD out of range");
   end
   if (ALL_RED < 1 || ALL_RED > RED_MAX) begin : g_bad_red
      $error("ALL_RED out of range");
   end

   state_e             state;
   state_e             state_n;
   dir_e               last_dir;
   dir_e               last_dir_n;
   dir_e               grant_dir;
   logic               ns_wait_q;
   logic               ew_wait_q;
   logic               last_wait;
   logic               oth_wait;
   logic               grant_ns;
   logic               grant_ew;

   logic [TIMER_W-1:0] t_cnt;
   logic               t_zero;
   logic               t_one;
   logic               t_load;
   logic               t_dec;

   logic [RED_W-1:0]   r_cnt;
   logic               r_zero;
   logic               r_one;
   logic               r_load;
   logic               r_dec;

   phase_counter #(
      .W       (TIMER_W),
      .RST_VAL (0)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (bus.tick),
      .load     (t_load),
      .dec      (t_dec),
      .load_val (TIMER_W'(LOAD)),
      .count    (t_cnt),
      .zero     (t_zero),
      .one      (t_one)
   );

   phase_counter #(
      .W       (RED_W),
      .RST_VAL (ALL_RED)
   ) u_red (
      .clk      (clk),
      .reset    (reset),
      .tick     (bus.tick),
      .load     (r_load),
      .dec      (r_dec),
      .load_val (RED_W'(ALL_RED)),
      .count    (r_cnt),
      .zero     (r_zero),
      .one      (r_one)
   );

   // Re-serve last_dir only if it alone is waiting; otherwise alternate.
   assign last_wait = (last_dir == NS) ? ns_wait_q : ew_wait_q;
   assign oth_wait  = (last_dir == NS) ? ew_wait_q : ns_wait_q;
   assign grant_dir = (last_wait && !oth_wait) ? last_dir
                                                : other_dir(last_dir);

   always_comb begin
      state_n    = state;
      last_dir_n = last_dir;
      t_load     = 1'b0;
      t_dec      = 1'b0;
      r_load     = 1'b0;
      r_dec      = 1'b0;
      grant_ns   = 1'b0;
      grant_ew   = 1'b0;
      unique case (state)
         CLEAR: begin
            if (bus.tick) begin
               if (r_one || r_zero) begin
                  t_load = 1'b1;
                  if (grant_dir == NS) begin
                     state_n  = NS_GO;
                     grant_ns = 1'b1;
                  end else begin
                     state_n  = EW_GO;
                     grant_ew = 1'b1;
                  end
               end else begin
                  r_dec = 1'b1;
               end
            end
         end
         NS_GO, EW_GO: begin
            if (bus.tick) begin
               t_dec = 1'b1;
               if (t_one || t_zero) begin
                  state_n    = CLEAR;
                  r_load     = 1'b1;
                  last_dir_n = (state == NS_GO) ? NS : EW;
               end
            end
         end
         default: state_n = CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CLEAR;
         last_dir <= EW;
      end else begin
         state    <= state_n;
         last_dir <= last_dir_n;
      end
   end

   // Grant clears the latch even if the sensor is still asserted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ns_wait_q <= 1'b0;
         ew_wait_q <= 1'b0;
      end else begin
         if (grant_ns) begin
            ns_wait_q <= 1'b0;
         end else if (bus.car_ns && state != NS_GO) begin
            ns_wait_q <= 1'b1;
         end
         if (grant_ew) begin
            ew_wait_q <= 1'b0;
         end else if (bus.car_ew && state != EW_GO) begin
            ew_wait_q <= 1'b1;
         end
      end
   end

   assign bus.ns_enable = (state == NS_GO);
   assign bus.ew_enable = (state == EW_GO);
   assign bus.ns_timer  = (state == NS_GO) ? t_cnt : '0;
   assign bus.ew_timer  = (state == EW_GO) ? t_cnt : '0;
   assign bus.ns_wait   = ns_wait_q;
   assign bus.ew_wait   = ew_wait_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: vector table through a queue,
// mid-phase reset sequence and a random invariant run.
module tb_intersection_controller;
   import intersection_pkg::*;

   localparam int LOAD    = 20;
   localparam int ALL_RED = 2;
   localparam int NVEC    = 22;

   typedef logic [17:0] obs_t;

   typedef struct {
      int   cyc;
      logic tick;
      logic cn;
      logic ce;
      obs_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs [NVEC];
   obs_t exp_q [$];

   intersection_controller_if bus ();

   intersection_controller #(
      .LOAD    (LOAD),
      .ALL_RED (ALL_RED)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic obs_t eo(logic ne, int nt, logic ee, int et,
                               logic nw, logic ew);
      return {ne, 7'(nt), ee, 7'(et), nw, ew};
   endfunction

   function automatic vec_t mk(int c, logic t, logic cn, logic ce,
                               logic ne, int nt, logic ee, int et,
                               logic nw, logic ew);
      vec_t v;
      v.cyc  = c;
      v.tick = t;
      v.cn   = cn;
      v.ce   = ce;
      v.exp  = eo(ne, nt, ee, et, nw, ew);
      return v;
   endfunction

   function automatic obs_t sample();
      return {bus.ns_enable, bus.ns_timer, bus.ew_enable, bus.ew_timer,
              bus.ns_wait, bus.ew_wait};
   endfunction

   task automatic check(input string nm, input int idx, input obs_t exp);
      obs_t got;
      got = sample();
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, got, exp);
      end
   endtask

   task automatic drive(input logic t, input logic cn, input logic ce);
      bus.tick   = t;
      bus.car_ns = cn;
      bus.car_ew = ce;
   endtask

   initial begin
      logic ok;
      int   ns_grants;
      int   ew_grants;
      logic prev_ne;
      logic prev_ee;

      // Fields: cycles, tick, car_ns, car_ew, then expected
      // ns_en, ns_t, ew_en, ew_t, ns_wait, ew_wait.
      vecs[0]  = mk( 1, 1, 0, 0,  0,  0, 0,  0, 0, 0);
      vecs[1]  = mk( 1, 1, 0, 0,  1, 20, 0,  0, 0, 0);
      vecs[2]  = mk(19, 1, 0, 0,  1,  1, 0,  0, 0, 0);
      vecs[3]  = mk( 1, 1, 0, 0,  0,  0, 0,  0, 0, 0);
      vecs[4]  = mk( 1, 1, 0, 0,  0,  0, 0,  0, 0, 0);
      vecs[5]  = mk( 1, 1, 0, 0,  0,  0, 1, 20, 0, 0);
      vecs[6]  = mk(19, 1, 0, 0,  0,  0, 1,  1, 0, 0);
      vecs[7]  = mk( 1, 1, 0, 0,  0,  0, 0,  0, 0, 0);
      vecs[8]  = mk( 2, 1, 0, 0,  1, 20, 0,  0, 0, 0);
      vecs[9]  = mk( 5, 1, 1, 0,  1, 15, 0,  0, 0, 0);
      vecs[10] = mk(50, 0, 0, 0,  1, 15, 0,  0, 0, 0);
      vecs[11] = mk( 1, 1, 0, 0,  1, 14, 0,  0, 0, 0);
      vecs[12] = mk(13, 1, 0, 0,  1,  1, 0,  0, 0, 0);
      vecs[13] = mk( 1, 1, 1, 0,  0,  0, 0,  0, 0, 0);
      vecs[14] = mk( 1, 1, 1, 0,  0,  0, 0,  0, 1, 0);
      vecs[15] = mk( 1, 1, 1, 0,  1, 20, 0,  0, 0, 0);
      vecs[16] = mk( 1, 1, 0, 1,  1, 19, 0,  0, 0, 1);
      vecs[17] = mk(18, 1, 0, 0,  1,  1, 0,  0, 0, 1);
      vecs[18] = mk( 1, 1, 1, 0,  0,  0, 0,  0, 0, 1);
      vecs[19] = mk( 1, 1, 1, 0,  0,  0, 0,  0, 1, 1);
      vecs[20] = mk( 1, 1, 0, 0,  0,  0, 1, 20, 1, 0);
      vecs[21] = mk(11, 1, 0, 0,  0,  0, 1,  9, 1, 0);

      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(eo(0, 0, 0, 0, 0, 0));
      check("reset_state", 0, exp_q.pop_front());
      reset = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].tick, vecs[i].cn, vecs[i].ce);
         exp_q.push_back(vecs[i].exp);
         repeat (vecs[i].cyc) @(posedge clk);
         #1;
         check("vec", i, exp_q.pop_front());
      end

      // Asynchronous reset mid-EW-phase, away from any clock edge.
      drive(1'b1, 1'b0, 1'b0);
      #3;
      reset = 1'b1;
      exp_q.push_back(eo(0, 0, 0, 0, 0, 0));
      #1;
      check("async_reset", 0, exp_q.pop_front());
      @(posedge clk);
      #1;
      exp_q.push_back(eo(0, 0, 0, 0, 0, 0));
      check("reset_hold", 0, exp_q.pop_front());
      reset = 1'b0;
      exp_q.push_back(eo(0, 0, 0, 0, 0, 0));
      exp_q.push_back(eo(1, 20, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check("post_reset", 1, exp_q.pop_front());
      @(posedge clk);
      #1;
      check("post_reset", 2, exp_q.pop_front());

      ns_grants = 0;
      ew_grants = 0;
      prev_ne   = bus.ns_enable;
      prev_ee   = bus.ew_enable;
      for (int c = 0; c < 10000; c++) begin
         drive(1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) == 0));
         @(posedge clk);
         #1;
         ok = !(bus.ns_enable && bus.ew_enable) &&
              !(bus.ns_enable && bus.ns_timer == '0) &&
              !(bus.ew_enable && bus.ew_timer == '0) &&
              !(prev_ne && bus.ew_enable) &&
              !(prev_ee && bus.ns_enable);
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL invariant[%0d] got=%b%b/%0d/%0d required=safe",
                     c, bus.ns_enable, bus.ew_enable,
                     bus.ns_timer, bus.ew_timer);
         end
         if (bus.ns_enable && !prev_ne) ns_grants++;
         if (bus.ew_enable && !prev_ee) ew_grants++;
         prev_ne = bus.ns_enable;
         prev_ee = bus.ew_enable;
      end

      n_tests++;
      if (ns_grants == 0 || ew_grants == 0) begin
         n_fail++;
         $display("FAIL random_progress got=%0d/%0d required=nonzero",
                  ns_grants, ew_grants);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
